// File: rtl/find_sched.sv
// find_sched: sequences the parallel find units through clear/run, collects their
// results, then scans for the minimum-energy unit and reports it.
module find_sched #(
  parameter int SEQ_WIDTH      = 8,
  parameter int E_WIDTH        = 16,
  parameter int PARALLEL_UNITS = 4,
  parameter int TIMEOUT_WIDTH  = 24,
  parameter int IDX_WIDTH      = PARALLEL_UNITS > 1 ? $clog2(PARALLEL_UNITS) : 1
)(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_start,
  input  logic                                i_abort,
  input  logic [TIMEOUT_WIDTH-1:0]            i_timeout,
  input  logic [PARALLEL_UNITS*SEQ_WIDTH-1:0] i_seq,
  input  logic [PARALLEL_UNITS*E_WIDTH-1:0]   i_e,
  input  logic [PARALLEL_UNITS-1:0]           i_done,
  output logic                                o_unit_rst,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_timeout,
  output logic [PARALLEL_UNITS-1:0]           o_done_mask,
  output logic                                o_best_valid,
  output logic [IDX_WIDTH-1:0]                o_best_unit,
  output logic [SEQ_WIDTH-1:0]                o_best_seq,
  output logic [E_WIDTH-1:0]                  o_best_e
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SCAN, REPORT} state_t;
  state_t state, next;
  logic clr;
  logic [TIMEOUT_WIDTH-1:0] cnt, tmo;
  logic [IDX_WIDTH-1:0] idx;
  logic [SEQ_WIDTH-1:0] hold_seq [PARALLEL_UNITS];
  logic [E_WIDTH-1:0] hold_e [PARALLEL_UNITS];
  logic all_done, tmo_hit, last_idx, active;
  assign all_done = &(o_done_mask | i_done);
  assign tmo_hit  = tmo != '0 && cnt == tmo - TIMEOUT_WIDTH'(1);
  assign last_idx = idx == IDX_WIDTH'(PARALLEL_UNITS - 1);
  assign active   = state inside {CLEAR, RUN, SCAN};
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = i_start ? CLEAR : IDLE;
      CLEAR:   next = i_abort ? IDLE : clr ? RUN : CLEAR;
      RUN:     next = i_abort ? IDLE : (all_done || tmo_hit) ? SCAN : RUN;
      SCAN:    next = i_abort ? IDLE : last_idx ? REPORT : SCAN;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      clr          <= 1'b0;
      cnt          <= '0;
      tmo          <= '0;
      idx          <= '0;
      o_unit_rst   <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_timeout    <= 1'b0;
      o_done_mask  <= '0;
      o_best_valid <= 1'b0;
      o_best_unit  <= '0;
      o_best_seq   <= '0;
      o_best_e     <= '1;
      for (int k = 0; k < PARALLEL_UNITS; k++) begin
        hold_seq[k] <= '0;
        hold_e[k]   <= '0;
      end
    end else begin
      state      <= next;
      o_unit_rst <= next != RUN;
      o_busy     <= next inside {CLEAR, RUN, SCAN};
      o_done     <= next == REPORT;
      case (state)
        IDLE: if (i_start) begin
          clr          <= 1'b0;
          cnt          <= '0;
          tmo          <= i_timeout;
          idx          <= '0;
          o_timeout    <= 1'b0;
          o_done_mask  <= '0;
          o_best_valid <= 1'b0;
          o_best_unit  <= '0;
          o_best_seq   <= '0;
          o_best_e     <= '1;
        end
        CLEAR: clr <= 1'b1;
        RUN: begin
          cnt <= &cnt ? cnt : cnt + TIMEOUT_WIDTH'(1);
          for (int k = 0; k < PARALLEL_UNITS; k++)
            if (i_done[k] && !o_done_mask[k]) begin
              o_done_mask[k] <= 1'b1;
              hold_seq[k]    <= i_seq[k*SEQ_WIDTH +: SEQ_WIDTH];
              hold_e[k]      <= i_e[k*E_WIDTH +: E_WIDTH];
            end
          if (tmo_hit && !all_done && !i_abort) o_timeout <= 1'b1;
        end
        SCAN: begin
          if (o_done_mask[idx] && (!o_best_valid || hold_e[idx] < o_best_e)) begin
            o_best_valid <= 1'b1;
            o_best_unit  <= idx;
            o_best_seq   <= hold_seq[idx];
            o_best_e     <= hold_e[idx];
          end
          idx <= idx + IDX_WIDTH'(1);
        end
        default: ;
      endcase
      // abort overrides any result the scan may have just produced
      if (i_abort && active) o_best_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_find_sched.sv
// tb_find_sched: directed runs of find_sched; results are queued by the stimulus
// and checked by a monitor whenever o_done pulses.
module tb_find_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_abort = 1'b0;
  logic [23:0] i_timeout = '0;
  logic [31:0] i_seq = '0;
  logic [63:0] i_e = '0;
  logic [3:0]  i_done = '0;
  logic        o_unit_rst, o_busy, o_done, o_timeout, o_best_valid;
  logic [3:0]  o_done_mask;
  logic [1:0]  o_best_unit;
  logic [7:0]  o_best_seq;
  logic [15:0] o_best_e;

  typedef struct {
    bit          valid;
    logic [1:0]  unit;
    logic [7:0]  seq;
    logic [15:0] e;
    bit          tmo;
    logic [3:0]  mask;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_ex;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  logic prev_done = 1'b0;

  find_sched dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_timeout(i_timeout), .i_seq(i_seq), .i_e(i_e), .i_done(i_done),
    .o_unit_rst(o_unit_rst), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
    .o_done_mask(o_done_mask), .o_best_valid(o_best_valid), .o_best_unit(o_best_unit),
    .o_best_seq(o_best_seq), .o_best_e(o_best_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_done) begin
      chk("done_width", prev_done, 0);
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_ex = sb.pop_front();
        chk("done_cycle", cyc, mon_ex.cyc);
        chk("best_valid", o_best_valid, mon_ex.valid);
        chk("best_unit", o_best_unit, mon_ex.unit);
        chk("best_seq", o_best_seq, mon_ex.seq);
        chk("best_e", o_best_e, mon_ex.e);
        chk("timeout", o_timeout, mon_ex.tmo);
        chk("done_mask", o_done_mask, mon_ex.mask);
        chk("busy_at_done", o_busy, 0);
      end
    end
    prev_done <= o_done;
  end

  task automatic wait_run_start();
    int t = 0;
    while (o_unit_rst && t < 20) begin @(negedge clk); t++; end
    chk("run_start", o_unit_rst, 0);
  endtask

  // dN: RUN cycle in which unit N raises i_done (-1 = never); last: final RUN cycle
  task automatic run(input logic [23:0] tmo, input int d0, d1, d2, d3,
                     input logic [31:0] seq, input logic [63:0] e,
                     input exp_t ex, input int last, input bit poke);
    int dc[4];
    logic [63:0] ev;
    int t;
    dc = '{d0, d1, d2, d3};
    ev = e;
    @(negedge clk);
    i_timeout = tmo; i_seq = seq; i_e = ev; i_done = '0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_run_start();
    ex.cyc = cyc + last + 5;
    sb.push_back(ex);
    for (int c = 0; c <= last; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (dc[k] >= 0 && c >= dc[k]) i_done[k] = 1'b1;
        if (dc[k] >= 0 && c > dc[k]) ev[k*16 +: 16] = 16'h0001;
      end
      i_e = ev;
      @(negedge clk);
    end
    if (poke) i_start = 1'b1;
    t = 0;
    while (!o_done && t < 20) begin @(negedge clk); t++; end
    chk("done_seen", o_done, 1);
    @(negedge clk);
    i_start = 1'b0;
    i_done = '0;
    if (poke) begin
      chk("start_ignored_a", o_busy, 0);
      @(negedge clk);
      chk("start_ignored_b", o_busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t ex;
    repeat (3) @(negedge clk);
    chk("rst_unit_rst", o_unit_rst, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_mask", o_done_mask, 0);
    chk("rst_valid", o_best_valid, 0);
    chk("rst_unit", o_best_unit, 0);
    chk("rst_seq", o_best_seq, 0);
    chk("rst_e", o_best_e, 16'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    ex = '{1, 2'd1, 8'h22, 16'h0010, 0, 4'hF, 0};
    run(24'd0, 5, 9, 3, 7, 32'h44332211, 64'h0010_0030_0010_0040, ex, 9, 1);

    ex = '{1, 2'd1, 8'h22, 16'h0080, 0, 4'hF, 0};
    run(24'd0, 0, 0, 0, 0, 32'h44332211, 64'h0200_0080_0080_0100, ex, 0, 1);

    ex = '{1, 2'd2, 8'hA5, 16'h0005, 1, 4'b0100, 0};
    run(24'd10, -1, -1, 3, -1, 32'h00A50000, 64'h0001_0005_0001_0001, ex, 9, 0);

    ex = '{0, 2'd0, 8'h00, 16'hFFFF, 1, 4'b0000, 0};
    run(24'd10, -1, -1, -1, -1, 32'h44332211, 64'h0001_0001_0001_0001, ex, 9, 0);

    ex = '{1, 2'd1, 8'h22, 16'h0020, 0, 4'hF, 0};
    run(24'd10, 2, 2, 2, 9, 32'h44332211, 64'h0040_0020_0020_0030, ex, 9, 0);

    // abort in RUN cycle 4
    @(negedge clk);
    i_timeout = '0; i_done = '0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_run_start();
    repeat (4) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_unit_rst", o_unit_rst, 1);
    chk("abort_valid", o_best_valid, 0);
    repeat (8) @(negedge clk);
    chk("abort_idle", o_busy, 0);

    // start and reset while scanning
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_run_start();
    i_done = 4'hF;
    @(negedge clk);
    chk("scan_busy", o_busy, 1);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_unit_rst", o_unit_rst, 1);
    chk("mid_rst_mask", o_done_mask, 0);
    chk("mid_rst_e", o_best_e, 16'hFFFF);
    @(negedge clk);
    i_done = '0;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", o_busy, 0);

    ex = '{1, 2'd1, 8'h22, 16'h0080, 0, 4'hF, 0};
    run(24'd0, 0, 0, 0, 0, 32'h44332211, 64'h0200_0080_0080_0100, ex, 0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/find_sched.md
FIND_SCHED -- requirements
Module: find_sched

Interface
REQ-001 Parameter SEQ_WIDTH, default 8, width of one unit's candidate sequence.
REQ-002 Parameter E_WIDTH, default 16, width of one unit's energy value.
REQ-003 Parameter PARALLEL_UNITS, default 4, number of find units scheduled; IDX_WIDTH = $clog2(PARALLEL_UNITS), minimum 1.
REQ-004 Parameter TIMEOUT_WIDTH, default 24, width of the run-cycle limit.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_start  input  1  one-cycle run request; honoured only in IDLE.
REQ-008 i_abort  input  1  cancels a run in progress.
REQ-009 i_timeout  input  TIMEOUT_WIDTH  max RUN cycles; 0 = no limit; latched at start.
REQ-010 i_seq  input  PARALLEL_UNITS*SEQ_WIDTH  unit k's sequence in bits [k*SEQ_WIDTH +: SEQ_WIDTH].
REQ-011 i_e  input  PARALLEL_UNITS*E_WIDTH  unit k's energy in bits [k*E_WIDTH +: E_WIDTH].
REQ-012 i_done  input  PARALLEL_UNITS  per-unit completion level.
REQ-013 o_unit_rst  output  1  active-high reset to all find units.
REQ-014 o_busy  output  1  high in CLEAR, RUN, SCAN.
REQ-015 o_done  output  1  one-cycle run-complete pulse.
REQ-016 o_timeout  output  1  last run ended by timeout; held until next start.
REQ-017 o_done_mask  output  PARALLEL_UNITS  sticky per-unit completion flags of current/last run.
REQ-018 o_best_valid, o_best_unit [IDX_WIDTH], o_best_seq [SEQ_WIDTH], o_best_e [E_WIDTH]  outputs  minimum-energy result; held until next start.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, RUN, SCAN, REPORT; all outputs registered.
REQ-020 IDLE: o_unit_rst=1; i_start=1 -> CLEAR; clears done_mask, o_timeout, o_best_valid, counter; o_best_e=all ones; latches i_timeout.
REQ-021 CLEAR: exactly 2 cycles, o_unit_rst=1, then RUN.
REQ-022 RUN: o_unit_rst=0; cycle counter increments from 0 each RUN cycle.
REQ-023 RUN: on each edge where i_done[k]=1 and done_mask[k]=0, set done_mask[k] and capture i_seq/i_e slice k into per-unit holding registers; later changes on unit k ignored.
REQ-024 RUN -> SCAN at the edge where (done_mask | i_done) becomes all ones.
REQ-025 RUN -> SCAN with o_timeout=1 when latched timeout != 0 and counter == timeout-1 and mask incomplete (RUN lasts at most timeout cycles).
REQ-026 Completion and timeout at same edge: completion wins, o_timeout=0.
REQ-027 SCAN: PARALLEL_UNITS cycles, index k=0..PARALLEL_UNITS-1 one per edge; masked-in unit k replaces best if not yet valid or captured e strictly less than o_best_e (unsigned); ties keep lower index.
REQ-028 On the edge processing the last index, SCAN -> REPORT and o_done=1; if final i_done sampled at edge T, o_done high during the cycle after edge T+PARALLEL_UNITS.
REQ-029 REPORT: one cycle, then IDLE with o_done=0.
REQ-030 No unit done at timeout: o_best_valid=0, o_best_unit=0, o_best_seq=0, o_best_e=all ones; o_done still pulses.
REQ-031 i_start outside IDLE ignored; i_start same cycle as REPORT ignored.
REQ-032 i_abort in CLEAR/RUN/SCAN -> IDLE next edge, no o_done, best outputs left as-is with o_best_valid=0; i_abort takes priority over completion/timeout; ignored in IDLE/REPORT.
REQ-033 Counter SHALL saturate, never wrap.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE, o_unit_rst=1, o_busy=0, o_done=0, o_timeout=0, o_done_mask=0, o_best_valid=0, o_best_unit=0, o_best_seq=0, o_best_e=all ones, counter 0, holding registers 0.
REQ-035 Reset mid-run SHALL leave no pulse on o_done after rst_n deasserts; first start thereafter behaves as after power-up.

Verification
REQ-036 Defaults; start, timeout=0, units finish at RUN cycles 5,9,3,7 with e=0x0040,0x0010,0x0030,0x0010 -> o_best_unit=1, o_best_e=0x0010, o_best_valid=1, o_timeout=0, mask=4'b1111.
REQ-037 All four i_done high in first RUN cycle (edge T) -> o_done high exactly cycle after T+4; o_busy low afterwards.
REQ-038 timeout=10, only unit 2 done (e=0x0005, seq=0xA5) -> o_done after 10 RUN cycles + 4, o_timeout=1, best unit 2, seq 0xA5, mask=4'b0100.
REQ-039 timeout=10, no unit done -> o_timeout=1, o_best_valid=0, o_best_e=0xFFFF; last done at counter 9 -> o_timeout=0.
REQ-040 i_abort in RUN cycle 4, i_start in SCAN, and rst_n pulsed in SCAN -> return to IDLE, no o_done, o_unit_rst=1, subsequent run correct.
